// File: rtl/imm_ext_if.sv
// imm_ext_if: request/response bundle between requesters and the shared immediate extender
interface imm_ext_if #(
   parameter int NREQ  = 2,
   parameter int IN_W  = 3,
   parameter int OUT_W = 8,
   parameter int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*IN_W-1:0] req_imm;
   logic [NREQ-1:0]      req_sext;
   logic [NREQ-1:0]      req_ready;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [OUT_W-1:0]     resp_data;
   logic [ID_W-1:0]      resp_id;
   logic                 busy;
   modport master (output req_valid, req_imm, req_sext, resp_ready,
                   input  req_ready, resp_valid, resp_data, resp_id, busy);
   modport slave  (input  req_valid, req_imm, req_sext, resp_ready,
                   output req_ready, resp_valid, resp_data, resp_id, busy);
endinterface

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin arbiter feeding one sign/zero immediate extender
module imm_ext_arbiter #(
   parameter int NREQ  = 2,
   parameter int IN_W  = 3,
   parameter int OUT_W = 8,
   parameter int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input logic        clk,
   input logic        rst_n,
   imm_ext_if.slave   bus
);
   logic [ID_W-1:0]   ptr, win, nxt;
   logic [ID_W:0]     s;
   logic [2*NREQ-1:0] rot;
   logic [IN_W-1:0]   imm;
   logic              sx, any, grant;
   logic [OUT_W-1:0]  ext;
   always_comb begin
      // rotate so bit 0 is the pointer's requester; lowest set bit wins
      rot = {bus.req_valid, bus.req_valid} >> ptr;
      s = '0;
      any = 1'b0;
      for (int k = NREQ-1; k >= 0; k--)
         if (rot[k]) begin
            s = {1'b0, ptr} + (ID_W+1)'(k);
            any = 1'b1;
         end
      win = (s >= (ID_W+1)'(NREQ)) ? ID_W'(s - (ID_W+1)'(NREQ)) : s[ID_W-1:0];
      nxt = (win == ID_W'(NREQ-1)) ? '0 : win + ID_W'(1);
      imm = '0;
      sx = 1'b0;
      for (int i = 0; i < NREQ; i++)
         if (win == ID_W'(i)) begin
            imm = bus.req_imm[i*IN_W +: IN_W];
            sx = bus.req_sext[i];
         end
      ext = {{(OUT_W-IN_W){sx & imm[IN_W-1]}}, imm};
      grant = rst_n & any & (~bus.resp_valid | bus.resp_ready);
      bus.req_ready = grant ? NREQ'(1) << win : '0;
   end
   assign bus.busy = bus.resp_valid & ~bus.resp_ready;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.resp_valid <= 1'b0;
         bus.resp_data <= '0;
         bus.resp_id <= '0;
         ptr <= '0;
      end else if (grant) begin
         bus.resp_valid <= 1'b1;
         bus.resp_data <= ext;
         bus.resp_id <= win;
         ptr <= nxt;
      end else if (bus.resp_ready)
         bus.resp_valid <= 1'b0;
   // a waiting requester must not withdraw or alter its immediate before grant
   for (genvar i = 0; i < NREQ; i++) begin : g_hold
      assert property (@(posedge clk) disable iff (!rst_n)
         bus.req_valid[i] && !bus.req_ready[i] |=>
         bus.req_valid[i] && $stable(bus.req_sext[i]) && $stable(bus.req_imm[i*IN_W +: IN_W]));
   end
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: randomized + directed scoreboard bench against a queue-level reference model
module tb_imm_ext_arbiter;
   localparam int N = 3, IW = 3, OW = 8, IDW = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   imm_ext_if #(.NREQ(N), .IN_W(IW), .OUT_W(OW), .ID_W(IDW)) bus ();
   imm_ext_arbiter #(.NREQ(N), .IN_W(IW), .OUT_W(OW), .ID_W(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   bit v[N];
   bit s[N];
   int im[N];
   logic rr = 1'b0;
   always_comb begin
      bus.req_valid = '0;
      bus.req_sext = '0;
      bus.req_imm = '0;
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i] = v[i];
         bus.req_sext[i] = s[i];
         bus.req_imm[i*IW +: IW] = IW'(im[i]);
      end
   end
   assign bus.resp_ready = rr;
   typedef struct { int d; int id; } exp_t;
   exp_t q[$];
   exp_t cur = '{0, 0};
   int n_cmp = 0, n_bad = 0, ptr = 0;
   bit exp_valid = 0, fresh = 0;
   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endfunction
   function automatic int ext(int val, bit sgn);
      return (sgn && val >= (1 << (IW-1))) ? val + (1 << OW) - (1 << IW) : val;
   endfunction
   // winner by the round-robin rule, -1 when no grant is possible
   function automatic int model_win();
      if (!rst_n || (exp_valid && !rr)) return -1;
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction
   task automatic cycle();
      int w;
      @(posedge clk);
      w = -1;
      if (rst_n) begin
         w = model_win();
         if (w >= 0) begin
            q.push_back('{ext(im[w], s[w]), w});
            exp_valid = 1;
            fresh = 1;
            ptr = (w + 1) % N;
         end else begin
            fresh = 0;
            if (rr) exp_valid = 0;
         end
      end
      #1;
      if (w >= 0) v[w] = 0;
   endtask
   task automatic set(int i, int val, bit sgn);
      v[i] = 1;
      im[i] = val;
      s[i] = sgn;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      q.delete();
      exp_valid = 0;
      fresh = 0;
      ptr = 0;
      cur = '{0, 0};
      repeat (2) cycle();
      rst_n = 1'b1;
   endtask
   task automatic expect_out(string name, int d, int id);
      @(negedge clk);
      #1;
      chk({name, "_data"}, 32'(bus.resp_data), d);
      chk({name, "_id"}, 32'(bus.resp_id), id);
   endtask
   always @(negedge clk) begin
      int w;
      if (!rst_n) begin
         chk("rst_valid", 32'(bus.resp_valid), 0);
         chk("rst_data", 32'(bus.resp_data), 0);
         chk("rst_id", 32'(bus.resp_id), 0);
         chk("rst_ready", 32'(bus.req_ready), 0);
      end else begin
         w = model_win();
         chk("req_ready", 32'(bus.req_ready), (w < 0) ? 0 : (1 << w));
         chk("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
         chk("busy", 32'(bus.busy), 32'(exp_valid && !rr));
         if (bus.resp_valid && fresh) begin
            fresh = 0;
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL scoreboard: response id %0d with none expected", bus.resp_id);
            end else cur = q.pop_front();
         end
         chk("resp_data", 32'(bus.resp_data), cur.d);
         chk("resp_id", 32'(bus.resp_id), cur.id);
      end
   end
   initial begin
      #1;
      do_reset();
      rr = 1'b1;
      set(0, 5, 1); cycle(); expect_out("t2_fd", 8'hFD, 0);
      set(0, 5, 0); cycle(); expect_out("t2_05", 8'h05, 0);
      set(0, 3, 1); cycle(); expect_out("t2_03", 8'h03, 0);
      cycle();
      cycle();
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < 2; i++)
            if (!v[i]) set(i, $urandom % 8, 1'($urandom % 2));
         cycle();
      end
      rr = 1'b0;
      repeat (3) cycle();
      rr = 1'b1;
      repeat (2) cycle();
      repeat (6) cycle();
      set(1, 1, 0); cycle();
      set(0, 6, 1); set(2, 2, 1); cycle(); expect_out("t5_first", 8'h02, 2);
      cycle(); expect_out("t5_second", 8'hFE, 0);
      cycle();
      set(0, 7, 1); cycle();
      rr = 1'b0;
      cycle();
      do_reset();
      rr = 1'b1;
      set(0, 4, 0); set(1, 1, 1); set(2, 2, 0); cycle(); expect_out("ptr_after_rst", 8'h04, 0);
      repeat (4) cycle();
      for (int c = 0; c < 400; c++) begin
         rr = ($urandom % 4) != 0;
         for (int i = 0; i < N; i++)
            if (!v[i] && ($urandom % 3) == 0) set(i, $urandom % 8, 1'($urandom % 2));
         if ($urandom % 150 == 0) do_reset();
         else cycle();
      end
      rr = 1'b1;
      repeat (6) cycle();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
